// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI memory host port among NUM_REQ requesters.
// Optional WAIT timeout with a DRAIN state for late completions: define SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int PW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_din,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rsp_dout,
    output logic                      rsp_err,
    output logic [PW-1:0]             gnt_id,
    output logic                      busy,
    output logic                      spi_wr,
    output logic [ADDR_W-1:0]         spi_addr,
    output logic [DATA_W-1:0]         spi_din,
    input  logic [DATA_W-1:0]         spi_dout,
    input  logic                      spi_done,
    input  logic                      spi_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("spi_req_arbiter: unsupported parameter set");
    end

`ifdef SPI_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DRAIN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
`endif

    state_t        state, state_n;
    logic [PW-1:0] ptr, win, ptr_n;
    logic          found;
    int            idx;

    // Search from ptr upward with wrap; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        ptr_n = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          tmo_hit;

    assign tmo_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Shared counter: WAIT timeout first, then the DRAIN window after a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt       <= '0;
                    timed_out <= 1'b0;
                end
                S_WAIT: begin
                    if (spi_done) begin
                        cnt <= '0;
                    end else if (tmo_hit) begin
                        cnt       <= '0;
                        timed_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RESP:  cnt <= '0;
                default: cnt <= cnt + CW'(1);
            endcase
        end
    end
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (found) state_n = S_WAIT;
            S_WAIT: begin
                if (spi_done) state_n = S_RESP;
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_hit) state_n = S_RESP;
`endif
            end
`ifdef SPI_ARB_TIMEOUT_EN
            S_RESP:  state_n = timed_out ? S_DRAIN : S_IDLE;
            S_DRAIN: if (spi_done || tmo_hit) state_n = S_IDLE;
`else
            S_RESP:  state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // SPI-side command and captured response; both hold until next overwrite.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            gnt_id   <= '0;
            spi_wr   <= 1'b0;
            spi_addr <= '0;
            spi_din  <= '0;
            rsp_dout <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        spi_wr   <= req_wr[win];
                        spi_addr <= req_addr[int'(win)*ADDR_W +: ADDR_W];
                        spi_din  <= req_din[int'(win)*DATA_W +: DATA_W];
                        gnt_id   <= win;
                        ptr      <= ptr_n;
                    end
                end
                S_WAIT: begin
                    if (spi_done) begin
                        rsp_dout <= spi_dout;
                        rsp_err  <= spi_err;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rsp_dout <= '0;
                        rsp_err  <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (state == S_RESP) ack[gnt_id] = 1'b1;
    end

    assign busy = (state != S_IDLE);

endmodule
